// File: rtl/rf_write_arbiter.sv
// Write-port sequencer for the 32x32 register file: clears every register after reset or
// on init_start, then round-robin arbitrates NREQ writers. Optional macro: RF_ZERO_PROTECT_EN.
module rf_write_arbiter #(
   parameter int NREQ      = 2,
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = 32,
   parameter int REG_COUNT = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     init_start,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*DATA_W-1:0]   req_data,
   output logic [NREQ-1:0]          gnt,
   output logic                     busy,
   output logic                     init_done,
   output logic                     rf_wr,
   output logic [ADDR_W-1:0]        rf_waddr,
   output logic [DATA_W-1:0]        rf_wdata
);
   localparam int PTR_W = $clog2(NREQ);

   typedef enum logic {CLEAR, RUN} state_t;
   state_t state, state_nxt;

   logic [ADDR_W-1:0] cnt;
   logic [PTR_W-1:0]  ptr, gidx, ptr_nxt;
   logic [NREQ-1:0]   mask, hi, pick;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic              clr_last, wr_ok;

   assign clr_last = (cnt == ADDR_W'(REG_COUNT - 1));

   // Requesters at/after ptr win first; lowest set bit of the masked vector, else wrap around.
   always_comb begin
      mask = '0;
      for (int i = 0; i < NREQ; i++) mask[i] = (PTR_W'(i) >= ptr);
      hi   = req & mask;
      pick = (|hi) ? (hi & (-hi)) : (req & (-req));
   end

   always_comb begin
      gidx     = '0;
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick[i]) begin
            gidx     = PTR_W'(i);
            sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            sel_data = req_data[i*DATA_W +: DATA_W];
         end
      end
      ptr_nxt = (gidx == PTR_W'(NREQ - 1)) ? '0 : gidx + PTR_W'(1);
   end

`ifdef RF_ZERO_PROTECT_EN
   // Register 0 is hard-wired: the handshake completes but the write is swallowed.
   assign wr_ok = |sel_addr;
`else
   assign wr_ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= CLEAR;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         CLEAR:   if (clr_last)   state_nxt = RUN;
         RUN:     if (init_start) state_nxt = CLEAR;
         default: state_nxt = CLEAR;
      endcase
   end

   always_comb begin
      busy      = (state == CLEAR);
      init_done = (state == RUN);
      gnt       = (state == RUN && !init_start) ? pick : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_wr    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         cnt      <= '0;
         ptr      <= '0;
      end else if (state == CLEAR) begin
         rf_wr    <= 1'b1;
         rf_waddr <= cnt;
         rf_wdata <= '0;
         cnt      <= clr_last ? '0 : cnt + ADDR_W'(1);
      end else if (|gnt) begin
         rf_wr    <= wr_ok;
         rf_waddr <= sel_addr;
         rf_wdata <= sel_data;
         ptr      <= ptr_nxt;
      end else begin
         rf_wr    <= 1'b0;
      end
   end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: a queue-based reference model predicts grants and
// register-file writes; a negedge monitor pops and compares.
module tb_rf_write_arbiter;
   localparam int N = 2, AW = 5, DW = 32, RC = 32;

   logic clk = 1'b0, rst_n = 1'b1, init_start = 1'b0;
   logic [N-1:0]    req = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]    gnt;
   logic            busy, init_done, rf_wr;
   logic [AW-1:0]   rf_waddr;
   logic [DW-1:0]   rf_wdata;

   rf_write_arbiter #(.NREQ(N), .ADDR_W(AW), .DATA_W(DW), .REG_COUNT(RC)) dut (
      .clk(clk), .rst_n(rst_n), .init_start(init_start), .req(req), .req_addr(req_addr),
      .req_data(req_data), .gnt(gnt), .busy(busy), .init_done(init_done), .rf_wr(rf_wr),
      .rf_waddr(rf_waddr), .rf_wdata(rf_wdata));

   always #5 clk = ~clk;

   typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
   wr_t sb[$];
   int total = 0, bad = 0;

   bit            pend[N];
   logic [AW-1:0] paddr[N];
   logic [DW-1:0] pdata[N];
   bit            m_clear, mon_en = 1'b0, exp_busy;
   int            m_idx, m_ptr;
   logic [N-1:0]  exp_gnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic mreset();
      m_clear = 1'b1; m_idx = 0; m_ptr = 0;
      sb.delete();
   endtask

   // Reference model for one cycle, using the inputs just driven.
   task automatic step(input bit ist);
      wr_t e;
      bit  found;
      int  g;
      init_start = ist;
      for (int i = 0; i < N; i++) begin
         req[i] = pend[i];
         req_addr[i*AW +: AW] = paddr[i];
         req_data[i*DW +: DW] = pdata[i];
      end
      exp_gnt = '0;
      if (m_clear) begin
         exp_busy = 1'b1;
         e.a = AW'(m_idx); e.d = '0;
         sb.push_back(e);
         m_idx++;
         if (m_idx == RC) begin m_clear = 1'b0; m_idx = 0; end
      end else begin
         exp_busy = 1'b0;
         if (ist) begin
            m_clear = 1'b1; m_idx = 0;
         end else begin
            found = 1'b0; g = 0;
            for (int k = 0; k < N; k++) begin
               if (!found && pend[(m_ptr + k) % N]) begin found = 1'b1; g = (m_ptr + k) % N; end
            end
            if (found) begin
               exp_gnt[g] = 1'b1;
               e.a = paddr[g]; e.d = pdata[g];
`ifdef RF_ZERO_PROTECT_EN
               if (paddr[g] != '0)
`endif
               sb.push_back(e);
               m_ptr = (g + 1) % N;
               pend[g] = 1'b0;
            end
         end
      end
      mon_en = 1'b1;
   endtask

   task automatic cyc(input bit ist);
      @(posedge clk); #1;
      step(ist);
   endtask

   task automatic release_rst();
      @(posedge clk); #1;
      rst_n = 1'b1;
      mreset();
      step(1'b0);
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      pend[i] = 1'b1; paddr[i] = a; pdata[i] = d;
   endtask

   always @(negedge clk) begin
      wr_t e;
      if (!rst_n) begin
         chk("rst_rf_wr", 64'(rf_wr), 64'd0);
         chk("rst_init_done", 64'(init_done), 64'd0);
         chk("rst_busy", 64'(busy), 64'd1);
         chk("rst_gnt", 64'(gnt), 64'd0);
         chk("rst_waddr", 64'(rf_waddr), 64'd0);
         chk("rst_wdata", 64'(rf_wdata), 64'd0);
      end else if (mon_en) begin
         chk("gnt", 64'(gnt), 64'(exp_gnt));
         chk("busy", 64'(busy), 64'(exp_busy));
         chk("init_done", 64'(init_done), 64'(!exp_busy));
         if (rf_wr === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_write", 64'(rf_waddr), 64'hFFFF);
            end else begin
               e = sb.pop_front();
               chk("waddr", 64'(rf_waddr), 64'(e.a));
               chk("wdata", 64'(rf_wdata), 64'(e.d));
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < N; i++) begin pend[i] = 1'b0; paddr[i] = '0; pdata[i] = '0; end
      mreset();
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      release_rst();
      // Interrupt the power-up clear mid-way; it must restart from address 0.
      repeat (9) cyc(1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      mon_en = 1'b0;
      #1;
      chk("async_rf_wr", 64'(rf_wr), 64'd0);
      chk("async_init_done", 64'(init_done), 64'd0);
      mreset();
      repeat (2) @(posedge clk);
      release_rst();
      repeat (RC + 2) cyc(1'b0);

      set_req(0, 5'd5, 32'h0000_00AA);
      cyc(1'b0);
      cyc(1'b0);
      set_req(1, 5'd9, 32'h1234_5678);
      cyc(1'b0);
      for (int c = 0; c < 4; c++) begin
         set_req(0, 5'd3, 32'd1);
         set_req(1, 5'd7, 32'd2);
         cyc(1'b0);
      end
      pend[0] = 1'b0; pend[1] = 1'b0;
      cyc(1'b0);

      // init_start beats a pending request; req0 waits out the clear.
      set_req(0, 5'd12, 32'hCAFE_0001);
      cyc(1'b1);
      repeat (RC + 3) cyc(1'b0);

      set_req(0, 5'd0, 32'hFFFF_FFFF);
      cyc(1'b0);
      cyc(1'b0);

      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++)
            if (!pend[i] && ($urandom % 3 != 0))
               set_req(i, AW'($urandom), $urandom);
         cyc(($urandom % 60) == 0);
      end
      pend[0] = 1'b0; pend[1] = 1'b0;
      repeat (RC + 4) cyc(1'b0);
      @(negedge clk); #1;
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Sequences and shares the single write port (wr/Rw/Din) of the 32x32 register file among NREQ requesters.
- After reset, and on command, a clear sequencer walks every register and writes zero. It then moves to round-robin arbitration of write requests.
- Sits directly in front of the register file write port. Read ports are untouched.

Parameters:
- NREQ, 2, number of write requesters (2..8).
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- REG_COUNT, 32, number of registers cleared by the sequencer (at most 2**ADDR_W).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- init_start  input  1  request a full register clear; level sampled at the clock edge.
- req  input  NREQ  per-requester write request.
- req_addr  input  NREQ*ADDR_W  flattened target addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  input  NREQ*DATA_W  flattened write data; requester i occupies bits [i*DATA_W +: DATA_W].
- gnt  output  NREQ  one-hot grant, combinational, valid in the same cycle as the req it answers.
- busy  output  1  high while the clear sequence runs.
- init_done  output  1  high once a clear has completed and the block is in RUN.
- rf_wr  output  1  registered write enable to the register file.
- rf_waddr  output  ADDR_W  registered write address.
- rf_wdata  output  DATA_W  registered write data.

Behaviour:
- Reset (rst_n low, asynchronous): rf_wr=0, rf_waddr=0, rf_wdata=0, busy=1, init_done=0, gnt=0, clear counter=0, round-robin pointer=0, state=CLEAR.
- States: CLEAR, RUN.
- CLEAR, per cycle:
  - Register rf_wr=1, rf_waddr=cnt, rf_wdata=0, then cnt++.
  - When cnt=REG_COUNT-1 is issued: cnt returns to 0 and state becomes RUN.
  - gnt is held at 0 for the whole state; requests stall.
  - init_start is ignored.
  - Exactly REG_COUNT writes are issued, on consecutive cycles, at addresses 0..REG_COUNT-1.
- RUN:
  - busy=0, init_done=1.
  - If init_start=1: enter CLEAR next cycle. No grant is issued in that cycle, and init_start has priority over req. init_done=0 from the next cycle until the clear completes.
  - Otherwise, if any req is set: gnt goes one-hot to the first requester set at or after the pointer (searching upward, modulo NREQ).
  - At the next edge: rf_wr=1, rf_waddr/rf_wdata take the granted requester's fields, and the pointer becomes (granted index+1) mod NREQ.
  - If no req: rf_wr=0 next cycle; rf_waddr/rf_wdata hold their previous values.
- Handshake:
  - A requester holds req, addr and data stable until it sees gnt=1.
  - A transfer completes in the cycle where req&gnt is high.
  - A requester may keep req high to issue back-to-back writes. With other requesters pending, the round-robin rotation still applies.
- Latency: one cycle from the req&gnt cycle to rf_wr high. Throughput is one write per cycle.
- Fairness: with all NREQ requesters continuously requesting, each one is granted exactly once in every NREQ consecutive cycles.
- Reset mid-operation: a write in flight is dropped, and a full clear restarts after rst_n deasserts.

Optional Feature:
- Macro RF_ZERO_PROTECT_EN, which makes register 0 hard-wired to zero.
- When defined:
  - RUN-state requests addressed to 0 are still granted (the handshake completes).
  - The registered rf_wr is forced to 0 for those requests.
  - CLEAR still writes zero to address 0.
- When undefined: address 0 is writable like any other register.

Test Plan:
- Reset release, with init_start=0 and req=0:
  - rf_wr is high for exactly 32 cycles, rf_waddr runs 0..31, rf_wdata=0.
  - busy falls and init_done rises on the cycle after address 31 is written.
- In RUN, req=2'b01, addr0=5, data0=32'h0000_00AA: gnt=2'b01 in the same cycle; next cycle rf_wr=1, rf_waddr=5, rf_wdata=32'hAA.
- In RUN, req=2'b11 held for 4 cycles with addr0=3/data0=1 and addr1=7/data1=2:
  - Grants alternate 01,10,01,10.
  - rf_waddr sequence is 3,7,3,7.
- In RUN, init_start=1 pulsed together with req=2'b01:
  - gnt stays 0 in that cycle; the next 32 cycles are clear writes.
  - The pending req0 is granted only after init_done returns to 1.
- Assert rst_n=0 during the clear at cnt=10: rf_wr and init_done drop to 0 immediately; after release the clear restarts at address 0.
- With RF_ZERO_PROTECT_EN defined, in RUN, req0 with addr=0 and data=32'hFFFF_FFFF: gnt0=1, and rf_wr stays 0 on the following cycle.
